// File: rtl/mux4x1_rr_arbiter_pkg.sv
// rtl/mux4x1_rr_arbiter_pkg.sv - shared widths, state codes and helpers for the 4:1 mux arbiter
package mux4x1_rr_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

endpackage

// File: rtl/mux4x1_rr_arbiter_pick.sv
// rtl/mux4x1_rr_arbiter_pick.sv - rotating first-set-bit search over four requests
module rr_pick4
  import mux4x1_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk from the far end back to ptr so the candidate closest to ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4x1_rr_arbiter.sv
// rtl/mux4x1_rr_arbiter.sv - round-robin arbiter driving the select of a shared 4:1 mux
module mux4x1_rr_arbiter
  import mux4x1_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  arb_state_t       state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [N_REQ-1:0] gnt_n;
  logic [SEL_W-1:0] sel_n;

  logic [N_REQ-1:0] req_others;
  logic [SEL_W-1:0] pick_ptr;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic [CNT_W-1:0] hold_lim;
  logic             owner_req;
  logic             preempt;

  // While granted, sel is the owner; the search starts just past it and ignores it.
  assign req_others = req & ~gnt;
  assign pick_ptr   = (state == ST_GRANT) ? sel + SEL_W'(1) : ptr;
  assign hold_lim   = (MAX_HOLD == 0) ? '1 : CNT_W'(MAX_HOLD);
  assign owner_req  = req[sel];
  assign preempt    = (MAX_HOLD != 0) && owner_req && (cnt == hold_lim) && pick_found;

  rr_pick4 u_pick (
    .req   (req_others),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    gnt_n   = gnt;
    sel_n   = sel;
    unique case (state)
      ST_IDLE: begin
        if (pick_found) begin
          gnt_n   = onehot(pick_idx);
          sel_n   = pick_idx;
          cnt_n   = CNT_W'(1);
          state_n = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!owner_req || preempt) begin
          ptr_n = sel + SEL_W'(1);
          if (pick_found) begin
            gnt_n = onehot(pick_idx);
            sel_n = pick_idx;
            cnt_n = CNT_W'(1);
          end else begin
            gnt_n   = '0;
            cnt_n   = '0;
            state_n = ST_IDLE;
          end
        end else if (cnt != hold_lim) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
      cnt   <= '0;
      gnt   <= '0;
      sel   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      gnt   <= gnt_n;
      sel   <= sel_n;
    end
  end

  assign busy = |gnt;

endmodule

// File: tb/tb_mux4x1_rr_arbiter.sv
// tb/tb_mux4x1_rr_arbiter.sv - directed self-checking bench for mux4x1_rr_arbiter
module tb_mux4x1_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;

  int n_cmp;
  int n_bad;

  mux4x1_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .sel   (sel),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    n_cmp++;
    if ({gnt, sel, busy} !== 7'b0000_00_0) begin
      n_bad++;
      $display("FAIL reset_state: gnt=%b sel=%b busy=%b want 0000 00 0", gnt, sel, busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_grant();
    do_reset();
    req = 4'b0100;
    tick();
    n_cmp++;
    if ({gnt, sel, busy} !== 7'b0100_10_1) begin
      n_bad++;
      $display("FAIL single_grant: gnt=%b sel=%b busy=%b want 0100 10 1", gnt, sel, busy);
    end
    req = 4'b0000;
    tick();
    n_cmp++;
    if ({gnt, sel, busy} !== 7'b0000_10_0) begin
      n_bad++;
      $display("FAIL single_release: gnt=%b sel=%b busy=%b want 0000 10 0", gnt, sel, busy);
    end
    tick();
    n_cmp++;
    if ({gnt, sel, busy} !== 7'b0000_10_0) begin
      n_bad++;
      $display("FAIL idle_hold: gnt=%b sel=%b busy=%b want 0000 10 0", gnt, sel, busy);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0010;
    tick();
    n_cmp++;
    if (gnt !== 4'b0010) begin
      n_bad++;
      $display("FAIL pre_async_grant: gnt=%b want 0010", gnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({gnt, sel, busy} !== 7'b0000_00_0) begin
      n_bad++;
      $display("FAIL async_reset: gnt=%b sel=%b busy=%b want 0000 00 0", gnt, sel, busy);
    end
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] req_seq [5];
    logic [3:0] gnt_exp [5];
    logic [1:0] sel_exp [5];
    req_seq = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};
    gnt_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    sel_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req = req_seq[i];
      tick();
      n_cmp++;
      if ({gnt, sel, busy} !== {gnt_exp[i], sel_exp[i], 1'b1}) begin
        n_bad++;
        $display("FAIL round_robin[%0d]: gnt=%b sel=%0d busy=%b want %b %0d 1",
                 i, gnt, sel, busy, gnt_exp[i], sel_exp[i]);
      end
    end
  endtask

  task automatic test_max_hold();
    int held;
    do_reset();
    req = 4'b0001;
    tick();
    req  = 4'b0011;
    held = 0;
    for (int i = 0; i < 8; i++) begin
      if (gnt === 4'b0001) held++;
      tick();
    end
    n_cmp++;
    if (held != 8) begin
      n_bad++;
      $display("FAIL max_hold_len: cycles=%0d want 8", held);
    end
    n_cmp++;
    if ({gnt, sel} !== 6'b0010_01) begin
      n_bad++;
      $display("FAIL max_hold_preempt: gnt=%b sel=%b want 0010 01", gnt, sel);
    end
  endtask

  task automatic test_saturate();
    int held;
    do_reset();
    req  = 4'b1000;
    held = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt === 4'b1000) held++;
    end
    n_cmp++;
    if (held != 20) begin
      n_bad++;
      $display("FAIL solo_hold: cycles=%0d want 20", held);
    end
    // A saturated counter preempts on the very next edge once someone else asks.
    req = 4'b1001;
    tick();
    n_cmp++;
    if ({gnt, sel} !== 6'b0001_00) begin
      n_bad++;
      $display("FAIL saturate_preempt: gnt=%b sel=%b want 0001 00", gnt, sel);
    end
  endtask

  task automatic test_reset_ptr();
    do_reset();
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0100;
    tick();
    n_cmp++;
    if (gnt !== 4'b0100) begin
      n_bad++;
      $display("FAIL ptr_setup: gnt=%b want 0100", gnt);
    end
    rst_n = 1'b0;
    req   = 4'b1010;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({gnt, sel} !== 6'b0010_01) begin
      n_bad++;
      $display("FAIL ptr_after_reset: gnt=%b sel=%b want 0010 01", gnt, sel);
    end
    req = 4'b1000;
    tick();
    n_cmp++;
    if ({gnt, sel} !== 6'b1000_11) begin
      n_bad++;
      $display("FAIL ptr_handoff: gnt=%b sel=%b want 1000 11", gnt, sel);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    test_reset();
    test_single_grant();
    test_async_reset();
    test_round_robin();
    test_max_hold();
    test_saturate();
    test_reset_ptr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
